ex_muldiv_seq: RTL and testbench
================================

# ex_muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide instructions, placed in the EX stage beside the single-cycle ALU. It accepts one OP instruction with funct7 = 0000001 from the decoder and computes the result iteratively: shift-add for multiply, restoring division for divide. It stalls the pipeline while busy and presents the result for exactly one cycle when done.

## Interface
- No parameters; width fixed at 32.
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  request from decode/EX; sampled only in IDLE
- i_funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_A  in  32  rs1 operand; sampled with i_start
- i_B  in  32  rs2 operand; sampled with i_start
- i_flush  in  1  kill the in-flight operation (branch/trap redirect)
- o_busy  out  1  high in PREP, CALC and FIX
- o_stall  out  1  holds the pipeline: o_busy | (IDLE & i_start & ~i_flush)
- o_done  out  1  one-cycle pulse; o_result is valid in that cycle
- o_result  out  32  final result; held until the next accepted start

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: if i_start & ~i_flush, latch funct3, A and B, then go to PREP. Otherwise stay.
- PREP:
  - Record operand signs. A is signed for MULH, MULHSU, DIV and REM. B is signed for MULH, DIV and REM.
  - Load the magnitudes and clear the 5-bit iteration counter and the 64-bit accumulator.
  - Special cases (divide ops only) go straight to DONE with o_result loaded:
    - B == 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
    - Signed overflow (A == 0x80000000, B == 0xFFFFFFFF, DIV/REM): DIV gives 0x80000000, REM gives 0.
  - Otherwise go to CALC.
- CALC: one iteration per cycle, counter 0..31, then go to FIX after iteration 31.
  - Multiply: unsigned shift-add of the magnitudes, producing a 64-bit product.
  - Divide: restoring division. Shift the remainder left by 1 and bring in the next dividend bit. Trial-subtract the divisor. If the difference is non-negative, keep it and shift 1 into the quotient; otherwise shift in 0.
- FIX: apply signs, then load o_result and go to DONE.
  - Product is negated if signA ^ signB. MUL takes the low 32 bits; MULH, MULHSU and MULHU take the high 32 bits.
  - Quotient is negated if signA ^ signB. Remainder is negated if signA.
- DONE: o_done = 1 for this cycle only, then go to IDLE. An i_start asserted in DONE is ignored; o_stall is low in DONE so the instruction retires.
- i_flush in any state: go to IDLE on the next edge. No o_done is produced and o_result keeps its prior value. i_flush has priority over i_start.
- Reset: state IDLE, o_busy 0, o_done 0, o_stall 0, o_result 0, all internal registers 0.
- Unsigned operands with bit 31 set are never treated as negative. Internal adders are 33 bits wide, so the divide trial subtraction needs no separate borrow logic.

## Timing
- Let edge 0 be the edge that samples i_start in IDLE.
- Normal path: PREP in cycle 1, CALC in cycles 2..33, FIX in cycle 34, DONE in cycle 35. o_done is high 35 cycles after edge 0.
- Short path (divide by zero or overflow): PREP in cycle 1, DONE in cycle 2.
- o_stall is high combinationally in the request cycle and stays high through FIX.
- Back-to-back operation: the earliest next start is sampled in the IDLE cycle right after DONE.
- o_result only changes on the edge into DONE, or on reset.

## Structure
- Package ex_muldiv_pkg holds:
  - the state enum (IDLE, PREP, CALC, FIX, DONE);
  - funct3 localparams (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU);
  - the M-extension funct7 constant 7'b000_0001 used by the decoder.
- One sub-module, ex_muldiv_dp: the operand, accumulator, quotient and remainder registers, the 33-bit adder/subtractor and the sign-fix negators. Its controls are load, step, mode and fix.
- The FSM, counter and handshake live in ex_muldiv_seq.

## Test plan
- MUL, A = 7, B = 0xFFFFFFFD (-3) -> o_done at cycle 35, o_result 0xFFFFFFEB. o_stall high in cycles 0..34 and low in cycle 35.
- MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU, A = 0xFFFFFFFF, B = 2 -> 0xFFFFFFFF.
- DIV, A = 0xFFFFFFF9 (-7), B = 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU, 100 / 7 -> 14. REMU, 100 / 7 -> 2.
- DIVU, A = 5, B = 0 -> o_done at cycle 2, o_result 0xFFFFFFFF. REM, 0x80000000 / 0xFFFFFFFF -> o_done at cycle 2, o_result 0.
- Flush: start MUL, then assert i_flush at cycle 10. State is IDLE at cycle 11, o_done never pulses and o_result is unchanged. A new start at cycle 12 (DIVU 9/3) -> o_done at cycle 47, o_result 3.
- Reset at cycle 20 of a DIV -> next cycle all outputs 0 and state IDLE. Start asserted during DONE is ignored; a start asserted in the following IDLE cycle is accepted.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the RV32M multi-cycle multiply/divide unit.
//   state_e       : sequencer FSM states
//   F3*           : funct3 encodings of the RV32M ops
//   Funct7Muldiv  : funct7 value that selects the M extension in the decoder
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StCalc,
    StFix,
    StDone
  } state_e;

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  localparam logic [6:0] Funct7Muldiv = 7'b000_0001;

endpackage

// File: rtl/ex_muldiv_dp.sv
// Datapath for the multiply/divide sequencer.
//   clk_i, rst_i : clock, synchronous active-high reset
//   capture_i    : latch raw operands a_i/b_i
//   load_i       : record signs, load magnitudes, clear accumulator; loads the
//                  special-case result when special_o is set
//   step_i       : one shift-add (multiply) or restoring-divide iteration
//   fix_i        : apply signs and load result_o
//   mode_i       : latched funct3
//   special_o    : divide-by-zero or signed-overflow case (valid after capture)
//   result_o     : result register
module ex_muldiv_dp
  import ex_muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        capture_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        fix_i,
  input  logic [2:0]  mode_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        special_o,
  output logic [31:0] result_o
);

  logic [31:0] a_q, b_q, mag_a_q, mag_b_q, result_q;
  logic [63:0] acc_q;
  logic        sign_a_q, sign_b_q;

  logic        is_div, a_signed, b_signed, neg_a, neg_b, keep;
  logic [31:0] special_val, quo, rem, fixed;
  logic [32:0] add_x, add_y, sum;
  logic [63:0] prod;

  always_comb begin
    is_div   = mode_i[2];
    a_signed = (mode_i == F3Mulh) || (mode_i == F3Mulhsu) || (mode_i == F3Div) ||
               (mode_i == F3Rem);
    b_signed = (mode_i == F3Mulh) || (mode_i == F3Div) || (mode_i == F3Rem);
    neg_a    = a_signed & a_q[31];
    neg_b    = b_signed & b_q[31];

    special_o = is_div & ((b_q == 32'h0) ||
                (~mode_i[0] & (a_q == 32'h8000_0000) & (b_q == 32'hFFFF_FFFF)));
    if (b_q == 32'h0) special_val = mode_i[1] ? a_q : 32'hFFFF_FFFF;
    else              special_val = mode_i[1] ? 32'h0 : 32'h8000_0000;

    // Shared 33-bit adder: multiply adds the multiplicand into the high half,
    // divide subtracts the divisor from the shifted remainder (x + ~y + 1).
    if (is_div) begin
      add_x = {acc_q[63:32], mag_a_q[31]};
      add_y = ~{1'b0, mag_b_q};
    end else begin
      add_x = {1'b0, acc_q[63:32]};
      add_y = mag_b_q[0] ? {1'b0, mag_a_q} : 33'h0;
    end
    sum  = add_x + add_y + 33'(is_div);
    keep = ~sum[32];

    prod  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo   = (sign_a_q ^ sign_b_q) ? -acc_q[31:0] : acc_q[31:0];
    rem   = sign_a_q ? -acc_q[63:32] : acc_q[63:32];
    if (is_div)              fixed = mode_i[1] ? rem : quo;
    else if (mode_i == F3Mul) fixed = prod[31:0];
    else                     fixed = prod[63:32];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
    end else begin
      if (capture_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      if (load_i) begin
        sign_a_q <= neg_a;
        sign_b_q <= neg_b;
        mag_a_q  <= neg_a ? -a_q : a_q;
        mag_b_q  <= neg_b ? -b_q : b_q;
        acc_q    <= '0;
        if (special_o) result_q <= special_val;
      end
      if (step_i) begin
        if (is_div) begin
          // acc high = remainder, acc low = quotient; dividend bits come from mag_a
          acc_q   <= {keep ? sum[31:0] : add_x[31:0], acc_q[30:0], keep};
          mag_a_q <= {mag_a_q[30:0], 1'b0};
        end else begin
          acc_q   <= {sum, acc_q[31:1]};
          mag_b_q <= {1'b0, mag_b_q[31:1]};
        end
      end
      if (fix_i) result_q <= fixed;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer (EX stage).
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : request, sampled only in IDLE
//   i_funct3     : RV32M op
//   i_A, i_B     : rs1/rs2 operands, sampled with i_start
//   i_flush      : kill in-flight op, priority over i_start
//   o_busy       : high in PREP, CALC, FIX
//   o_stall      : pipeline hold
//   o_done       : one-cycle result-valid pulse
//   o_result     : result, held until the next completed op
module ex_muldiv_seq
  import ex_muldiv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_result
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic        capture, load, step, fix, special;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    capture = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    // Datapath controls stay low on flush so o_result keeps its prior value.
    if (i_flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            capture = 1'b1;
            f3_d    = i_funct3;
            state_d = StPrep;
          end
        end
        StPrep: begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = special ? StDone : StCalc;
        end
        StCalc: begin
          step  = 1'b1;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = StFix;
        end
        StFix: begin
          fix     = 1'b1;
          state_d = StDone;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    o_busy  = (state_q == StPrep) || (state_q == StCalc) || (state_q == StFix);
    o_stall = o_busy | ((state_q == StIdle) & i_start & ~i_flush);
    o_done  = (state_q == StDone);
  end

  ex_muldiv_dp u_dp (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .capture_i (capture),
    .load_i    (load),
    .step_i    (step),
    .fix_i     (fix),
    .mode_i    (f3_q),
    .a_i       (i_A),
    .b_i       (i_B),
    .special_o (special),
    .result_o  (o_result)
  );

endmodule

// File: tb/tb_ex_muldiv_seq.sv
module tb_ex_muldiv_seq;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  f3;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] result;

  always #5 clk = ~clk;

  ex_muldiv_seq dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_funct3 (f3),
    .i_A      (a),
    .i_B      (b),
    .i_flush  (flush),
    .o_busy   (busy),
    .o_stall  (stall),
    .o_done   (done),
    .o_result (result)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] exp_res_q[$];
  int          exp_cyc_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // Monitor: every o_done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_res_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc);
      end else begin
        string       t;
        logic [31:0] r;
        int          c;
        t = tag_q.pop_front();
        r = exp_res_q.pop_front();
        c = exp_cyc_q.pop_front();
        check({t, "_result"}, result, r);
        check({t, "_cycle"}, 32'(cyc), 32'(c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_done(input logic [31:0] res, input int lat, input string tag);
    exp_res_q.push_back(res);
    exp_cyc_q.push_back(cyc + lat);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_res_q.size() > 0 && k < 80) begin
      tick();
      k++;
    end
    if (exp_res_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: got %0d pending results, want 0", exp_res_q.size());
      exp_res_q.delete();
      exp_cyc_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] res, input int lat, input string tag);
    expect_done(res, lat, tag);
    start = 1'b1;
    f3    = op;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    f3    = '0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_result", result, 32'h0);

    // MUL 7 * -3 with stall profile over cycles 0..35
    expect_done(32'hFFFF_FFEB, 35, "mul_7_m3");
    start = 1'b1;
    f3    = F3Mul;
    a     = 32'd7;
    b     = 32'hFFFF_FFFD;
    @(negedge clk);
    check("mul_stall_c0", 32'(stall), 32'h1);
    for (int i = 1; i <= 35; i++) begin
      tick();
      start = 1'b0;
      @(negedge clk);
      check($sformatf("mul_stall_c%0d", i), 32'(stall), (i < 35) ? 32'h1 : 32'h0);
    end
    tick();
    drain();

    run(F3Mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, "mulhu_m1");
    run(F3Mulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 35, "mulh_m1");
    run(F3Mulhsu, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 35, "mulhsu_m1_2");
    run(F3Mulhu,  32'h8000_0000, 32'd4,         32'h0000_0002, 35, "mulhu_big");
    run(F3Div,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35, "div_m7_2");
    run(F3Rem,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35, "rem_m7_2");
    run(F3Div,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, "div_7_m2");
    run(F3Rem,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 35, "rem_7_m2");
    run(F3Divu,   32'd5,         32'd0,         32'hFFFF_FFFF, 2,  "divu_by0");
    run(F3Rem,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2,  "rem_ovf");
    run(F3Div,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  "div_ovf");
    run(F3Div,    32'd5,         32'd0,         32'hFFFF_FFFF, 2,  "div_by0");
    run(F3Remu,   32'h1234_5678, 32'd0,         32'h1234_5678, 2,  "remu_by0");
    run(F3Divu,   32'd100,       32'd7,         32'd14,        35, "divu_100_7");
    run(F3Remu,   32'd100,       32'd7,         32'd2,         35, "remu_100_7");

    // Flush in cycle 10 of a MUL; then DIVU 9/3 started in cycle 12
    start = 1'b1;
    f3    = F3Mul;
    a     = 32'd3;
    b     = 32'd5;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_stall", 32'(stall), 32'h0);
    check("flush_result_kept", result, 32'd2);
    tick();
    run(F3Divu, 32'd9, 32'd3, 32'd3, 35, "divu_after_flush");

    // Reset in cycle 20 of a DIV
    start = 1'b1;
    f3    = F3Div;
    a     = 32'd100;
    b     = 32'd7;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_stall", 32'(stall), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_result", result, 32'h0);
    tick();

    // Start held in DONE is ignored, accepted in the following IDLE cycle
    expect_done(32'hFFFF_FFFF, 2, "done_first");
    start = 1'b1;
    f3    = F3Divu;
    a     = 32'd5;
    b     = 32'd0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    f3    = F3Remu;
    a     = 32'd77;
    b     = 32'd0;
    @(negedge clk);
    check("done_stall_low", 32'(stall), 32'h0);
    tick();
    expect_done(32'd77, 2, "idle_accept");
    tick();
    start = 1'b0;
    drain();

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
